// File: rtl/x_mem_banked_if.sv
// Request/response bundle for x_mem_banked; i_perr_inj exists only when
// X_MEM_BANKED_PARITY_EN is defined.
interface x_mem_banked_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 11,
  parameter int SLICE_W = 2
);
  localparam int NSLICE = DATA_W / SLICE_W;

  logic              i_req;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [NSLICE-1:0] i_wmask;
  logic [DATA_W-1:0] i_wdata;
  logic              i_clr;
`ifdef X_MEM_BANKED_PARITY_EN
  logic              i_perr_inj;
`endif
  logic              o_ready;
  logic              o_busy;
  logic              o_rvalid;
  logic [DATA_W-1:0] o_rdata;
  logic              o_perr;

`ifdef X_MEM_BANKED_PARITY_EN
  modport master (
    output i_req, i_we, i_addr, i_wmask, i_wdata, i_clr, i_perr_inj,
    input  o_ready, o_busy, o_rvalid, o_rdata, o_perr
  );
  modport slave (
    input  i_req, i_we, i_addr, i_wmask, i_wdata, i_clr, i_perr_inj,
    output o_ready, o_busy, o_rvalid, o_rdata, o_perr
  );
`else
  modport master (
    output i_req, i_we, i_addr, i_wmask, i_wdata, i_clr,
    input  o_ready, o_busy, o_rvalid, o_rdata, o_perr
  );
  modport slave (
    input  i_req, i_we, i_addr, i_wmask, i_wdata, i_clr,
    output o_ready, o_busy, o_rvalid, o_rdata, o_perr
  );
`endif
endinterface

// File: rtl/x_mem_banked.sv
// Banked single-port RAM with masked writes, 3-cycle read pipe and clear sequencer.
// Optional per-slice even parity storage enabled by macro X_MEM_BANKED_PARITY_EN.
module x_mem_banked #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 11,
  parameter int SLICE_W = 2
) (
  input logic           i_clk,
  input logic           i_nrst,
  x_mem_banked_if.slave bus
);
  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic logic [DATA_W-1:0] expand_mask(input logic [NSLICE-1:0] mask);
    logic [DATA_W-1:0] bits;
    bits = '0;
    for (int s = 0; s < NSLICE; s++) begin
      bits[s*SLICE_W +: SLICE_W] = {SLICE_W{mask[s]}};
    end
    return bits;
  endfunction

`ifdef X_MEM_BANKED_PARITY_EN
  function automatic logic [NSLICE-1:0] slice_parity(input logic [DATA_W-1:0] word);
    logic [NSLICE-1:0] par;
    par = '0;
    for (int s = 0; s < NSLICE; s++) begin
      par[s] = ^word[s*SLICE_W +: SLICE_W];
    end
    return par;
  endfunction
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              s1_rd_q, s1_rd_d;
  logic              s1_we_q, s1_we_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic [NSLICE-1:0] s1_wmask_q, s1_wmask_d;
  logic [DATA_W-1:0] s1_wdata_q, s1_wdata_d;

  logic              s2_rd_q, s2_rd_d;
  logic [DATA_W-1:0] s2_rdata_q, s2_rdata_d;

  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem_array [DEPTH];
  logic [DATA_W-1:0] wr_word;

`ifdef X_MEM_BANKED_PARITY_EN
  logic              s1_pinj_q, s1_pinj_d;
  logic [NSLICE-1:0] s2_par_q, s2_par_d;
  logic              perr_q, perr_d;
  logic [NSLICE-1:0] mem_par [DEPTH];
  logic [NSLICE-1:0] wr_par;
`endif

  // Next state of the clear sequencer / run FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          state_d = ST_CLEAR;
          cnt_d   = cnt_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.i_clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Stage-1 source: the sequencer while clearing, the request port while running
  always_comb begin
    s1_rd_d    = 1'b0;
    s1_we_d    = 1'b0;
    s1_addr_d  = '0;
    s1_wmask_d = '0;
    s1_wdata_d = '0;
`ifdef X_MEM_BANKED_PARITY_EN
    s1_pinj_d  = 1'b0;
`endif
    case (state_q)
      ST_CLEAR: begin
        s1_we_d    = 1'b1;
        s1_addr_d  = cnt_q;
        s1_wmask_d = '1;
      end
      ST_RUN: begin
        if (bus.i_req) begin
          s1_rd_d    = ~bus.i_we;
          s1_we_d    = bus.i_we;
          s1_addr_d  = bus.i_addr;
          s1_wmask_d = bus.i_wmask;
          s1_wdata_d = bus.i_wdata;
`ifdef X_MEM_BANKED_PARITY_EN
          s1_pinj_d  = bus.i_perr_inj;
`endif
        end else begin
          s1_rd_d = 1'b0;
          s1_we_d = 1'b0;
        end
      end
      default: begin
        s1_rd_d = 1'b0;
        s1_we_d = 1'b0;
      end
    endcase
  end

  // Array access: masked merge for writes, synchronous read into stage 2
  always_comb begin
    wr_word    = (mem_array[s1_addr_q] & ~expand_mask(s1_wmask_q))
               | (s1_wdata_q & expand_mask(s1_wmask_q));
    s2_rd_d    = s1_rd_q;
    s2_rdata_d = s2_rdata_q;
`ifdef X_MEM_BANKED_PARITY_EN
    wr_par     = (mem_par[s1_addr_q] & ~s1_wmask_q)
               | ((slice_parity(s1_wdata_q) ^ {NSLICE{s1_pinj_q}}) & s1_wmask_q);
    s2_par_d   = s2_par_q;
`endif
    if (s1_rd_q) begin
      s2_rdata_d = mem_array[s1_addr_q];
`ifdef X_MEM_BANKED_PARITY_EN
      s2_par_d   = mem_par[s1_addr_q];
`endif
    end else begin
      s2_rdata_d = s2_rdata_q;
    end
  end

  // Output stage; o_rdata holds its value between read pulses
  always_comb begin
    rvalid_d = s2_rd_q;
    rdata_d  = rdata_q;
`ifdef X_MEM_BANKED_PARITY_EN
    perr_d   = 1'b0;
`endif
    if (s2_rd_q) begin
      rdata_d = s2_rdata_q;
`ifdef X_MEM_BANKED_PARITY_EN
      perr_d  = |(slice_parity(s2_rdata_q) ^ s2_par_q);
`endif
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Control and pipeline registers
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      s1_rd_q    <= 1'b0;
      s1_we_q    <= 1'b0;
      s1_addr_q  <= '0;
      s1_wmask_q <= '0;
      s1_wdata_q <= '0;
      s2_rd_q    <= 1'b0;
      s2_rdata_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
`ifdef X_MEM_BANKED_PARITY_EN
      s1_pinj_q  <= 1'b0;
      s2_par_q   <= '0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_rd_q    <= s1_rd_d;
      s1_we_q    <= s1_we_d;
      s1_addr_q  <= s1_addr_d;
      s1_wmask_q <= s1_wmask_d;
      s1_wdata_q <= s1_wdata_d;
      s2_rd_q    <= s2_rd_d;
      s2_rdata_q <= s2_rdata_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
`ifdef X_MEM_BANKED_PARITY_EN
      s1_pinj_q  <= s1_pinj_d;
      s2_par_q   <= s2_par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  // Storage write port; a write pending at a reset edge is discarded
  always_ff @(posedge i_clk) begin
    if (i_nrst && s1_we_q) begin
      mem_array[s1_addr_q] <= wr_word;
`ifdef X_MEM_BANKED_PARITY_EN
      mem_par[s1_addr_q]   <= wr_par;
`endif
    end
  end

  assign bus.o_ready  = (state_q == ST_RUN);
  assign bus.o_busy   = (state_q == ST_CLEAR);
  assign bus.o_rvalid = rvalid_q;
  assign bus.o_rdata  = rdata_q;
`ifdef X_MEM_BANKED_PARITY_EN
  assign bus.o_perr   = perr_q;
`else
  assign bus.o_perr   = 1'b0;
`endif

endmodule

// File: tb/tb_x_mem_banked.sv
// Self-checking bench for x_mem_banked: directed scenarios plus a randomized
// run against an array-based reference model.
module tb_x_mem_banked;
  localparam int DEPTH = 2048;
  localparam int NRND  = 300;

  logic clk = 1'b0;
  logic nrst;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] model [0:DEPTH-1];
  logic [7:0] last_rd;
  bit         exp_v [0:NRND-1];
  logic [7:0] exp_d [0:NRND-1];

  always #5 clk = ~clk;

  x_mem_banked_if #(.DATA_W(8), .ADDR_W(11), .SLICE_W(2)) bus ();

  x_mem_banked #(.DATA_W(8), .ADDR_W(11), .SLICE_W(2)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus.slave)
  );

  task automatic idle_inputs();
    bus.i_req   = 1'b0;
    bus.i_we    = 1'b0;
    bus.i_addr  = 11'd0;
    bus.i_wmask = 4'd0;
    bus.i_wdata = 8'd0;
    bus.i_clr   = 1'b0;
`ifdef X_MEM_BANKED_PARITY_EN
    bus.i_perr_inj = 1'b0;
`endif
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
  endtask

  task automatic model_write(input logic [10:0] a, input logic [3:0] m, input logic [7:0] d);
    for (int s = 0; s < 4; s++) begin
      if (m[s]) model[a][2*s +: 2] = d[2*s +: 2];
    end
  endtask

  // Present one request at the current falling edge, hold it across one rising edge.
  task automatic issue(input logic we, input logic [10:0] a, input logic [3:0] m, input logic [7:0] d);
    bus.i_req   = 1'b1;
    bus.i_we    = we;
    bus.i_addr  = a;
    bus.i_wmask = m;
    bus.i_wdata = d;
    if (we && bus.o_ready === 1'b1) model_write(a, m, d);
    @(negedge clk);
    bus.i_req   = 1'b0;
    bus.i_we    = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (bus.o_ready !== 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_run: o_ready=%b after %0d cycles, required 1", bus.o_ready, n);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    idle_inputs();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (bus.o_busy !== 1'b1)   begin errors++; $display("FAIL rst_busy: got %b required 1", bus.o_busy); end
    if (bus.o_ready !== 1'b0)  begin errors++; $display("FAIL rst_ready: got %b required 0", bus.o_ready); end
    if (bus.o_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b required 0", bus.o_rvalid); end
    if (bus.o_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h required 00", bus.o_rdata); end
    nrst = 1'b1;
    while (bus.o_busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    checks += 2;
    if (n != 2048) begin errors++; $display("FAIL busy_len: got %0d required 2048", n); end
    if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL ready_after_clear: got %b required 1", bus.o_ready); end
    model_clear();
    last_rd = 8'h00;
  endtask

  task automatic test_clear_reads();
    logic [10:0] addrs [3];
    addrs[0] = 11'd0; addrs[1] = 11'd1023; addrs[2] = 11'd2047;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, addrs[i], 4'h0, 8'h00);
      for (int k = 1; k <= 3; k++) begin
        if (k > 1) @(negedge clk);
        checks++;
        if (bus.o_rvalid !== (k == 3)) begin
          errors++; $display("FAIL clr_rd_lat a=%0d k=%0d: rvalid=%b required %b", addrs[i], k, bus.o_rvalid, (k == 3));
        end
      end
      checks++;
      if (bus.o_rdata !== model[addrs[i]]) begin
        errors++; $display("FAIL clr_rd_data a=%0d: got %h required %h", addrs[i], bus.o_rdata, model[addrs[i]]);
      end
      last_rd = model[addrs[i]];
    end
  endtask

  task automatic test_write_read();
    issue(1'b1, 11'h123, 4'hF, 8'hA5);
    issue(1'b0, 11'h123, 4'h0, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (bus.o_rvalid !== (k == 3)) begin
        errors++; $display("FAIL raw_lat k=%0d: rvalid=%b required %b", k, bus.o_rvalid, (k == 3));
      end
    end
    checks++;
    if (bus.o_rdata !== 8'hA5) begin errors++; $display("FAIL raw_data: got %h required a5", bus.o_rdata); end
    last_rd = 8'hA5;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) issue(1'b1, 11'h200 + 11'(i), 4'hF, 8'($urandom));
    fork
      begin
        for (int i = 0; i < 5; i++) issue(1'b0, 11'h200 + 11'(i), 4'h0, 8'h00);
      end
      begin
        for (int k = 1; k <= 8; k++) begin
          @(negedge clk);
          checks++;
          if (bus.o_rvalid !== (k >= 3 && k <= 7)) begin
            errors++; $display("FAIL b2b_valid k=%0d: rvalid=%b required %b", k, bus.o_rvalid, (k >= 3 && k <= 7));
          end
          if (k >= 3 && k <= 7) begin
            last_rd = model[11'h200 + 11'(k - 3)];
            checks++;
            if (bus.o_rdata !== last_rd) begin
              errors++; $display("FAIL b2b_data k=%0d: got %h required %h", k, bus.o_rdata, last_rd);
            end
          end
        end
      end
    join
  endtask

  task automatic test_mask();
    issue(1'b1, 11'd7, 4'hF, 8'hFF);
    issue(1'b1, 11'd7, 4'b0101, 8'h00);
    issue(1'b0, 11'd7, 4'h0, 8'h00);
    repeat (2) @(negedge clk);
    checks += 2;
    if (bus.o_rvalid !== 1'b1) begin errors++; $display("FAIL mask_valid: got %b required 1", bus.o_rvalid); end
    if (bus.o_rdata !== 8'hCC) begin errors++; $display("FAIL mask_data: got %h required cc", bus.o_rdata); end
    last_rd = 8'hCC;
  endtask

  task automatic test_random();
    fork
      begin
        for (int t = 0; t < NRND; t++) begin
          logic [10:0] a;
          logic [7:0]  d;
          logic [3:0]  m;
          logic        we;
          a = 11'($urandom_range(0, 15));
          d = 8'($urandom);
          m = 4'($urandom);
          we = 1'($urandom);
          exp_v[t] = 1'b0;
          exp_d[t] = 8'h00;
          if ($urandom_range(0, 3) == 0) begin
            bus.i_req = 1'b0;
          end else begin
            bus.i_req = 1'b1; bus.i_we = we; bus.i_addr = a; bus.i_wmask = m; bus.i_wdata = d;
            if (we) model_write(a, m, d);
            else begin exp_v[t] = 1'b1; exp_d[t] = model[a]; end
          end
          @(negedge clk);
        end
        idle_inputs();
      end
      begin
        for (int t = 1; t <= NRND + 3; t++) begin
          bit v;
          @(negedge clk);
          v = (t >= 3 && t - 3 < NRND) ? exp_v[t-3] : 1'b0;
          if (v) last_rd = exp_d[t-3];
          checks += 3;
          if (bus.o_rvalid !== v) begin errors++; $display("FAIL rnd_valid t=%0d: got %b required %b", t, bus.o_rvalid, v); end
          if (bus.o_rdata !== last_rd) begin errors++; $display("FAIL rnd_data t=%0d: got %h required %h", t, bus.o_rdata, last_rd); end
          if (bus.o_perr !== 1'b0) begin errors++; $display("FAIL rnd_perr t=%0d: got %b required 0", t, bus.o_perr); end
        end
      end
    join
  endtask

  task automatic test_clr_with_read();
    int n = 0;
    issue(1'b1, 11'h055, 4'hF, 8'h3C);
    bus.i_clr = 1'b1;
    issue(1'b0, 11'h055, 4'h0, 8'h00);
    bus.i_clr = 1'b0;
    for (int k = 1; k < 3000 && bus.o_busy === 1'b1; k++) begin
      if (k == 3) begin
        checks += 2;
        if (bus.o_rvalid !== 1'b1) begin errors++; $display("FAIL clr_rd_valid: got %b required 1", bus.o_rvalid); end
        if (bus.o_rdata !== 8'h3C) begin errors++; $display("FAIL clr_rd_data: got %h required 3c", bus.o_rdata); end
      end
      n++;
      @(negedge clk);
    end
    model_clear();
    last_rd = 8'h3C;
    checks++;
    if (n != 2048) begin errors++; $display("FAIL clr_busy_len: got %0d required 2048", n); end
    issue(1'b0, 11'h055, 4'h0, 8'h00);
    repeat (2) @(negedge clk);
    checks += 2;
    if (bus.o_rvalid !== 1'b1) begin errors++; $display("FAIL post_clr_valid: got %b required 1", bus.o_rvalid); end
    if (bus.o_rdata !== model[11'h055]) begin errors++; $display("FAIL post_clr_data: got %h required %h", bus.o_rdata, model[11'h055]); end
    last_rd = model[11'h055];
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int bad = 0;
    issue(1'b1, 11'd2000, 4'hF, 8'h77);
    issue(1'b1, 11'h123, 4'hF, 8'h3C);
    issue(1'b0, 11'h123, 4'h0, 8'h00);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    model_clear();
    last_rd = 8'h00;
    checks++;
    if (bus.o_rdata !== 8'h00) begin errors++; $display("FAIL midrst_rdata: got %h required 00", bus.o_rdata); end
    bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 11'h123;
    for (int k = 0; k < 500; k++) begin
      if (bus.o_rvalid !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL clear_read_ignored: %0d rvalid pulses, required 0", bad); end
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    idle_inputs();
    while (bus.o_busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 2048) begin errors++; $display("FAIL restart_busy_len: got %0d required 2048", n); end
    issue(1'b0, 11'd2000, 4'h0, 8'h00);
    repeat (2) @(negedge clk);
    checks += 2;
    if (bus.o_rvalid !== 1'b1) begin errors++; $display("FAIL restart_rd_valid: got %b required 1", bus.o_rvalid); end
    if (bus.o_rdata !== 8'h00) begin errors++; $display("FAIL restart_rd_data: got %h required 00", bus.o_rdata); end
    last_rd = 8'h00;
  endtask

`ifdef X_MEM_BANKED_PARITY_EN
  task automatic test_parity();
    for (int pass = 0; pass < 2; pass++) begin
      bus.i_perr_inj = (pass == 0);
      issue(1'b1, 11'h040, 4'hF, 8'h5A);
      bus.i_perr_inj = 1'b0;
      issue(1'b0, 11'h040, 4'h0, 8'h00);
      repeat (2) @(negedge clk);
      checks += 3;
      if (bus.o_rvalid !== 1'b1) begin errors++; $display("FAIL par_valid p=%0d: got %b required 1", pass, bus.o_rvalid); end
      if (bus.o_rdata !== 8'h5A) begin errors++; $display("FAIL par_data p=%0d: got %h required 5a", pass, bus.o_rdata); end
      if (bus.o_perr !== (pass == 0)) begin errors++; $display("FAIL par_perr p=%0d: got %b required %b", pass, bus.o_perr, (pass == 0)); end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear_reads();
    test_write_read();
    test_back_to_back();
    test_mask();
    test_random();
    test_clr_with_read();
    test_reset_mid();
`ifdef X_MEM_BANKED_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
